game_seq_ctrl: RTL and testbench
================================

Name: game_seq_ctrl

Overview:
Game-level sequencer for the breakout design. It owns the round flow: idle/attract, serve delay, play, life-lost pause, game over and win. It gates the ball and paddle animation and asserts ball re-centre. It keeps the lives counter and score, and drives the endgame flag consumed by the VGA driver and top level. It advances on the per-frame animate strobe and event pulses from the ball/block logic.

Parameters:
LIVES, 3, lives granted at game start (1..3)
SERVE_FRAMES, 60, animate strobes spent in SERVE before play
MISS_FRAMES, 90, animate strobes spent in MISS pause
SCORE_W, 9, score width
PTS_PER_HIT, 1, points added per block hit

Ports:
i_clk  in  1  system clock (100 MHz)
i_rst_n  in  1  asynchronous active-low reset
i_animate  in  1  one-cycle strobe, end of active frame
i_mode  in  1  game enabled; low forces IDLE
i_start  in  1  debounced start button, level
i_hit  in  1  one-cycle pulse, ball hit a block
i_miss  in  1  one-cycle pulse, ball passed the paddle line
i_clear  in  1  level, no blocks remain
o_state  out  3  current state encoding
o_ball_rst  out  1  hold ball at initial position
o_ball_en  out  1  ball motion enable
o_paddle_en  out  1  paddle motion enable
o_endgame  out  1  game finished (OVER or WIN)
o_win  out  1  game finished by clearing all blocks
o_lives  out  2  remaining lives
o_score  out  SCORE_W  current score

Behaviour:
- Reset is asynchronous on i_rst_n low. Reset values:
  - state = IDLE
  - o_lives = LIVES, o_score = 0
  - frame counter = 0
  - start-edge history register = 1, so a button held through reset must be released before it counts
- Start event = rising edge of i_start: i_start high with the history register low. The history register samples every cycle.
- State encodings: IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4, WIN=5. Encodings 6 and 7 return to IDLE on the next cycle.
- Outputs are Moore-decoded from the registered state. An output changes 1 cycle after the transition edge.
- Output decode per state:
  - IDLE: o_ball_rst=1; all enables 0.
  - SERVE: o_ball_rst=1, o_paddle_en=1.
  - PLAY: o_ball_en=1, o_paddle_en=1.
  - MISS: o_ball_rst=1; enables 0.
  - OVER: o_endgame=1, o_ball_rst=0.
  - WIN: o_endgame=1, o_win=1.
- Transitions:
  - IDLE: start event with i_mode=1 -> SERVE. On the same edge: lives <= LIVES, score <= 0, counter <= 0.
  - SERVE: counter increments on each i_animate. An i_animate while counter == SERVE_FRAMES-1 -> PLAY, counter <= 0.
  - PLAY, i_hit: score <= score + PTS_PER_HIT, saturating at 2^SCORE_W-1 (no wrap).
  - PLAY, i_miss with lives > 1: lives decrements -> MISS, counter <= 0.
  - PLAY, i_miss with lives == 1: lives <= 0 -> OVER.
  - PLAY, i_clear with no i_miss -> WIN.
  - MISS: an i_animate while counter == MISS_FRAMES-1 -> SERVE, counter <= 0.
  - OVER / WIN: hold score and lives. Start event -> IDLE. Score is cleared only on the next IDLE->SERVE.
- Simultaneous events:
  - i_hit with i_miss: score is still added, and the miss transition is taken.
  - i_miss with i_clear: the miss has priority.
  - i_hit with i_clear: score is added, then WIN.
- i_hit and i_miss are ignored outside PLAY. i_animate only advances the counter in SERVE and MISS.
- i_mode low in any state: -> IDLE on the next edge, counter <= 0, lives and score held. This takes priority over every other transition.
- Reset asserted mid-game returns immediately to the reset values. No event in flight is retained.
- Counter width is ceil(log2(max(SERVE_FRAMES, MISS_FRAMES))) bits. SERVE_FRAMES and MISS_FRAMES are each >= 1.

Test Plan:
- Reset release, i_start held high, i_mode=1 -> stays IDLE with o_ball_rst=1. Release then press -> SERVE, o_lives=3, o_score=0.
- SERVE with 59 animate strobes -> still SERVE. 60th strobe -> PLAY one cycle later: o_ball_en=1, o_ball_rst=0.
- PLAY, 5 i_hit pulses -> o_score=5. Preload score to 511 then i_hit -> o_score stays 511.
- PLAY, three i_miss pulses, each followed by 90 MISS strobes and 60 SERVE strobes:
  - after the 1st miss -> o_lives=2, MISS
  - after the 2nd miss -> o_lives=1, MISS
  - after the 3rd miss -> o_lives=0, OVER, o_endgame=1, score retained
- PLAY, i_miss and i_clear in the same cycle with o_lives=2 -> MISS, o_win=0. Separate run with i_hit and i_clear together -> WIN, o_win=1, score +1.
- i_mode dropped mid-PLAY -> IDLE next cycle. i_rst_n pulsed low mid-MISS -> immediately IDLE, o_lives=3, o_score=0.

Source files
------------

// File: rtl/game_seq_ctrl.sv
// Breakout round sequencer: idle/serve/play/miss/over/win flow, lives and score
// bookkeeping, and ball/paddle gating. Decoded outputs lag the state register by one clock.
module game_seq_ctrl #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 90,
  parameter int SCORE_W      = 9,
  parameter int PTS_PER_HIT  = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_animate,
  input  logic               i_mode,
  input  logic               i_start,
  input  logic               i_hit,
  input  logic               i_miss,
  input  logic               i_clear,
  output logic [2:0]         o_state,
  output logic               o_ball_rst,
  output logic               o_ball_en,
  output logic               o_paddle_en,
  output logic               o_endgame,
  output logic               o_win,
  output logic [1:0]         o_lives,
  output logic [SCORE_W-1:0] o_score
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   MISS_LAST  = CNT_W'(MISS_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [1:0]         LIVES_INIT = 2'(LIVES);
  // Decoded output bundle order: {ball_rst, ball_en, paddle_en, endgame, win}
  localparam logic [4:0]         OUTS_IDLE  = 5'b10000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4,
    ST_WIN   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               start_hist_q;
  logic [2:0]         state_out_q;
  logic [4:0]         outs_q, outs_d;
  logic               start_evt_s;

  function automatic logic [4:0] decode_outs(input state_e s);
    logic [4:0] v;
    case (s)
      ST_IDLE:  v = 5'b10000;
      ST_SERVE: v = 5'b10100;
      ST_PLAY:  v = 5'b01100;
      ST_MISS:  v = 5'b10000;
      ST_OVER:  v = 5'b00010;
      ST_WIN:   v = 5'b00011;
      default:  v = OUTS_IDLE;
    endcase
    return v;
  endfunction

  // Saturating add: widen by one bit so an overflow is visible before clamping.
  function automatic logic [SCORE_W-1:0] score_add(input logic [SCORE_W-1:0] s);
    logic [SCORE_W:0] sum;
    sum = {1'b0, s} + (SCORE_W + 1)'(PTS_PER_HIT);
    if (sum > {1'b0, SCORE_MAX}) begin
      return SCORE_MAX;
    end else begin
      return sum[SCORE_W-1:0];
    end
  endfunction

  assign start_evt_s = i_start & ~start_hist_q;

  // Next-state, counter, lives and score; i_mode low overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;
    score_d = score_q;
    outs_d  = decode_outs(state_q);
    if (!i_mode) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_evt_s) begin
            state_d = ST_SERVE;
            lives_d = LIVES_INIT;
            score_d = '0;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SERVE: begin
          if (i_animate) begin
            if (cnt_q == SERVE_LAST) begin
              state_d = ST_PLAY;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_PLAY: begin
          if (i_hit) begin
            score_d = score_add(score_q);
          end else begin
            score_d = score_q;
          end
          if (i_miss) begin
            cnt_d = '0;
            if (lives_q > 2'd1) begin
              lives_d = lives_q - 2'd1;
              state_d = ST_MISS;
            end else begin
              lives_d = 2'd0;
              state_d = ST_OVER;
            end
          end else if (i_clear) begin
            state_d = ST_WIN;
          end else begin
            state_d = ST_PLAY;
          end
        end
        ST_MISS: begin
          if (i_animate) begin
            if (cnt_q == MISS_LAST) begin
              state_d = ST_SERVE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_OVER, ST_WIN: begin
          if (start_evt_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, bookkeeping and registered Moore outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      lives_q      <= LIVES_INIT;
      score_q      <= '0;
      start_hist_q <= 1'b1;
      state_out_q  <= 3'd0;
      outs_q       <= OUTS_IDLE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      start_hist_q <= i_start;
      state_out_q  <= state_q;
      outs_q       <= outs_d;
    end
  end

  assign o_state     = state_out_q;
  assign o_ball_rst  = outs_q[4];
  assign o_ball_en   = outs_q[3];
  assign o_paddle_en = outs_q[2];
  assign o_endgame   = outs_q[1];
  assign o_win       = outs_q[0];
  assign o_lives     = lives_q;
  assign o_score     = score_q;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Self-checking bench for game_seq_ctrl: randomized gaps and noise pulses,
// compared against a behavioural game model kept in the bench.
module tb_game_seq_ctrl;

  localparam int LIVES        = 3;
  localparam int SERVE_FRAMES = 60;
  localparam int MISS_FRAMES  = 90;
  localparam int SCORE_W      = 9;
  localparam int SCORE_MAX    = (1 << SCORE_W) - 1;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_MISS = 3, S_OVER = 4, S_WIN = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic animate = 1'b0, mode = 1'b0, start = 1'b0, hit = 1'b0, miss = 1'b0, clear = 1'b0;
  logic [2:0]         o_state;
  logic               o_ball_rst, o_ball_en, o_paddle_en, o_endgame, o_win;
  logic [1:0]         o_lives;
  logic [SCORE_W-1:0] o_score;

  int errors = 0;
  int checks = 0;

  // Model: game state, the state shown on outputs (one clock behind), bookkeeping
  int m_state, m_ostate, m_lives, m_score, m_cnt;
  bit m_hist;

  // {ball_rst, ball_en, paddle_en, endgame, win} per state
  bit [4:0] flag_tab [0:5] = '{5'b10000, 5'b10100, 5'b01100, 5'b10000, 5'b00010, 5'b00011};

  logic [7:0] dut_v;
  assign dut_v = {o_state, o_ball_rst, o_ball_en, o_paddle_en, o_endgame, o_win};

  game_seq_ctrl dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_animate  (animate),
    .i_mode     (mode),
    .i_start    (start),
    .i_hit      (hit),
    .i_miss     (miss),
    .i_clear    (clear),
    .o_state    (o_state),
    .o_ball_rst (o_ball_rst),
    .o_ball_en  (o_ball_en),
    .o_paddle_en(o_paddle_en),
    .o_endgame  (o_endgame),
    .o_win      (o_win),
    .o_lives    (o_lives),
    .o_score    (o_score)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] exp_v();
    return {3'(m_ostate), flag_tab[m_ostate]};
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_ostate = S_IDLE; m_lives = LIVES; m_score = 0; m_cnt = 0; m_hist = 1'b1;
  endtask

  // Apply the game rules to the inputs present at the coming edge, then advance one clock.
  task automatic cycle();
    bit evt;
    evt = start && !m_hist;
    m_hist = start;
    m_ostate = m_state;
    if (!mode) begin
      m_state = S_IDLE; m_cnt = 0;
    end else if (m_state == S_IDLE) begin
      if (evt) begin m_state = S_SERVE; m_lives = LIVES; m_score = 0; m_cnt = 0; end
    end else if (m_state == S_SERVE || m_state == S_MISS) begin
      if (animate) begin
        m_cnt++;
        if (m_cnt == ((m_state == S_SERVE) ? SERVE_FRAMES : MISS_FRAMES)) begin
          m_state = (m_state == S_SERVE) ? S_PLAY : S_SERVE;
          m_cnt = 0;
        end
      end
    end else if (m_state == S_PLAY) begin
      if (hit) m_score = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
      if (miss) begin
        m_lives--;
        m_state = (m_lives == 0) ? S_OVER : S_MISS;
        m_cnt = 0;
      end else if (clear) begin
        m_state = S_WIN;
      end
    end else begin
      if (evt) m_state = S_IDLE;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_start();
    start = 1'b0; cycle();
    start = 1'b1; cycle();
    start = 1'b0;
  endtask

  // n animate strobes with random gaps carrying stray event pulses (ignored outside PLAY)
  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        hit = 1'($urandom_range(0, 1)); miss = 1'($urandom_range(0, 1)); clear = 1'($urandom_range(0, 1));
        cycle();
      end
      hit = 1'b0; miss = 1'b0; clear = 1'b0;
      animate = 1'b1; cycle();
      animate = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b1; start = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (dut_v !== 8'b000_10000 || o_lives !== 2'd3 || o_score !== 9'd0) begin
      errors++; $display("FAIL reset_values: got out=%b lives=%0d score=%0d want out=00010000 lives=3 score=0", dut_v, o_lives, o_score);
    end
    rst_n = 1'b1;
    repeat (5) cycle();
    checks++;
    if (o_state !== 3'd0 || dut_v !== exp_v()) begin
      errors++; $display("FAIL held_start_ignored: got out=%b want %b", dut_v, exp_v());
    end
    press_start();
    cycle();
    checks++;
    if (o_state !== 3'd1 || dut_v !== exp_v()) begin
      errors++; $display("FAIL start_to_serve: got out=%b want %b", dut_v, exp_v());
    end
    checks++;
    if (o_lives !== 2'd3 || o_score !== 9'd0) begin
      errors++; $display("FAIL start_counters: got lives=%0d score=%0d want 3 0", o_lives, o_score);
    end
  endtask

  task automatic test_serve();
    strobes(SERVE_FRAMES - 1);
    cycle(); cycle();
    checks++;
    if (o_state !== 3'd1 || dut_v !== exp_v()) begin
      errors++; $display("FAIL serve_59: got out=%b want %b", dut_v, exp_v());
    end
    animate = 1'b1; cycle(); animate = 1'b0;
    checks++;
    if (o_state !== 3'd1) begin
      errors++; $display("FAIL serve_lag: got state=%0d want 1", o_state);
    end
    cycle();
    checks++;
    if (o_state !== 3'd2 || o_ball_en !== 1'b1 || o_ball_rst !== 1'b0 || dut_v !== exp_v()) begin
      errors++; $display("FAIL serve_to_play: got out=%b want %b", dut_v, exp_v());
    end
  endtask

  task automatic test_score();
    for (int i = 0; i < 5; i++) begin
      hit = 1'b1; cycle(); hit = 1'b0;
      repeat ($urandom_range(0, 2)) cycle();
    end
    checks++;
    if (o_score !== 9'd5 || int'(o_score) != m_score) begin
      errors++; $display("FAIL score_5: got %0d want 5", o_score);
    end
    while (m_score < SCORE_MAX) begin
      hit = ($urandom_range(0, 3) != 0); cycle();
    end
    hit = 1'b0; cycle();
    checks++;
    if (o_score !== 9'd511) begin
      errors++; $display("FAIL score_max: got %0d want 511", o_score);
    end
    hit = 1'b1; cycle(); hit = 1'b0; cycle();
    checks++;
    if (o_score !== 9'd511 || int'(o_score) != m_score || dut_v !== exp_v()) begin
      errors++; $display("FAIL score_saturate: got %0d out=%b want 511 out=%b", o_score, dut_v, exp_v());
    end
  endtask

  task automatic test_miss_sequence();
    for (int k = 1; k <= 3; k++) begin
      miss = 1'b1; cycle(); miss = 1'b0; cycle();
      checks++;
      if (o_lives !== 2'(3 - k) || o_state !== ((k < 3) ? 3'd3 : 3'd4) || dut_v !== exp_v()) begin
        errors++; $display("FAIL miss_%0d: got lives=%0d out=%b want lives=%0d out=%b", k, o_lives, dut_v, 3 - k, exp_v());
      end
      if (k < 3) begin
        strobes(MISS_FRAMES); cycle(); cycle();
        checks++;
        if (o_state !== 3'd1 || dut_v !== exp_v()) begin
          errors++; $display("FAIL miss_to_serve_%0d: got out=%b want %b", k, dut_v, exp_v());
        end
        strobes(SERVE_FRAMES); cycle(); cycle();
        checks++;
        if (o_state !== 3'd2 || dut_v !== exp_v()) begin
          errors++; $display("FAIL reserve_play_%0d: got out=%b want %b", k, dut_v, exp_v());
        end
      end
    end
    checks++;
    if (o_endgame !== 1'b1 || o_win !== 1'b0 || o_score !== 9'd511 || o_lives !== 2'd0) begin
      errors++; $display("FAIL game_over: got eg=%b win=%b score=%0d lives=%0d want 1 0 511 0", o_endgame, o_win, o_score, o_lives);
    end
  endtask

  task automatic test_simultaneous();
    press_start(); press_start();
    strobes(SERVE_FRAMES); cycle();
    miss = 1'b1; clear = 1'b1; cycle(); miss = 1'b0; clear = 1'b0; cycle();
    checks++;
    if (o_state !== 3'd3 || o_win !== 1'b0 || o_lives !== 2'd2 || o_score !== 9'd0) begin
      errors++; $display("FAIL miss_beats_clear: got state=%0d win=%b lives=%0d score=%0d want 3 0 2 0", o_state, o_win, o_lives, o_score);
    end
    strobes(MISS_FRAMES); strobes(SERVE_FRAMES); cycle();
    hit = 1'b1; clear = 1'b1; cycle(); hit = 1'b0; clear = 1'b0; cycle();
    checks++;
    if (o_state !== 3'd5 || o_win !== 1'b1 || o_endgame !== 1'b1 || o_score !== 9'd1 || dut_v !== exp_v()) begin
      errors++; $display("FAIL hit_and_clear: got out=%b score=%0d want 10100011 score=1", dut_v, o_score);
    end
  endtask

  task automatic test_mode_drop();
    press_start(); press_start();
    strobes(SERVE_FRAMES); cycle();
    repeat (4) begin hit = 1'($urandom_range(0, 1)); cycle(); end
    hit = 1'b1; cycle(); hit = 1'b0;
    mode = 1'b0; cycle(); cycle();
    checks++;
    if (o_state !== 3'd0 || dut_v !== exp_v() || int'(o_score) != m_score || o_score === 9'd0 || int'(o_lives) != m_lives) begin
      errors++; $display("FAIL mode_drop: got out=%b score=%0d lives=%0d want %b %0d %0d", dut_v, o_score, o_lives, exp_v(), m_score, m_lives);
    end
    mode = 1'b1; cycle();
  endtask

  task automatic test_reset_mid_miss();
    press_start();
    strobes(SERVE_FRAMES); cycle();
    hit = 1'b1; cycle(); hit = 1'b0;
    miss = 1'b1; cycle(); miss = 1'b0;
    strobes(10); cycle();
    checks++;
    if (o_state !== 3'd3 || o_lives !== 2'd2 || dut_v !== exp_v()) begin
      errors++; $display("FAIL pre_reset_miss: got out=%b lives=%0d want %b 2", dut_v, o_lives, exp_v());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_state !== 3'd0 || o_ball_rst !== 1'b1 || o_lives !== 2'd3 || o_score !== 9'd0) begin
      errors++; $display("FAIL async_reset: got state=%0d rst=%b lives=%0d score=%0d want 0 1 3 0", o_state, o_ball_rst, o_lives, o_score);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle();
    checks++;
    if (dut_v !== exp_v() || int'(o_lives) != m_lives || int'(o_score) != m_score) begin
      errors++; $display("FAIL post_reset_idle: got out=%b want %b", dut_v, exp_v());
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_score();
    test_miss_sequence();
    test_simultaneous();
    test_mode_drop();
    test_reset_mid_miss();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
